// File: rtl/outport_sink.sv
// First-word fall-through out-port FIFO with a sticky overflow flag for dropped writes.
// Define OUTPORT_SINK_SEG7_EN to add last-popped-byte hex display outputs (display1/display2).
module outport_sink #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   input  logic                     clear_ovf
`ifdef OUTPORT_SINK_SEG7_EN
   ,
   output logic [7:0]               display1,
   output logic [7:0]               display2
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FullCount = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             push, pop, drop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == FullCount);
   assign out_valid = !empty;
   assign out_data  = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign overflow  = overflow_q;

   // A write while full is still accepted if the head leaves on the same edge.
   assign pop  = out_valid && out_ready;
   assign push = wr_en && (!full || pop);
   assign drop = wr_en && full && !pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (drop)           overflow_d = 1'b1;
      else if (clear_ovf) overflow_d = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: entries are unreachable once the pointers and count clear.
   always_ff @(posedge clock) begin
      if (push && !reset) mem_q[wr_ptr_q] <= wr_data;
   end

`ifdef OUTPORT_SINK_SEG7_EN
   logic [7:0] last_word_q;

   function automatic logic [7:0] seg7(input logic [3:0] digit);
      logic [7:0] seg;
      case (digit)
         4'h0: seg = 8'hC0;
         4'h1: seg = 8'hF9;
         4'h2: seg = 8'hA4;
         4'h3: seg = 8'hB0;
         4'h4: seg = 8'h99;
         4'h5: seg = 8'h92;
         4'h6: seg = 8'h82;
         4'h7: seg = 8'hF8;
         4'h8: seg = 8'h80;
         4'h9: seg = 8'h90;
         4'hA: seg = 8'h88;
         4'hB: seg = 8'h83;
         4'hC: seg = 8'hC6;
         4'hD: seg = 8'hA1;
         4'hE: seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset)    last_word_q <= '0;
      else if (pop) last_word_q <= out_data[7:0];
   end

   assign display1 = seg7(last_word_q[3:0]);
   assign display2 = seg7(last_word_q[7:4]);
`endif

endmodule

// File: tb/tb_outport_sink.sv
// Directed self-checking bench for outport_sink (DEPTH=4, WIDTH=32).
// Display checks are compiled in only when OUTPORT_SINK_SEG7_EN is defined.
module tb_outport_sink;

   logic        clock = 1'b0;
   logic        reset;
   logic        wrEn;
   logic [31:0] wrData;
   logic        outValid;
   logic        outReady;
   logic [31:0] outData;
   logic [2:0]  count;
   logic        full;
   logic        empty;
   logic        overflow;
   logic        clearOvf;
`ifdef OUTPORT_SINK_SEG7_EN
   logic [7:0]  display1;
   logic [7:0]  display2;
`endif

   int totalChecks = 0;
   int badChecks   = 0;

   outport_sink #(.DEPTH(4), .WIDTH(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (wrEn),
      .wr_data   (wrData),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_data  (outData),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .clear_ovf (clearOvf)
`ifdef OUTPORT_SINK_SEG7_EN
      ,
      .display1  (display1),
      .display2  (display2)
`endif
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, take a rising edge, and leave time 1 unit past it for sampling.
   task automatic applyStimulus(input logic we, input logic [31:0] data, input logic rdy, input logic clr);
      wrEn     = we;
      wrData   = data;
      outReady = rdy;
      clearOvf = clr;
      @(posedge clock);
      #1;
      wrEn     = 1'b0;
      outReady = 1'b0;
      clearOvf = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; wrEn = 1'b0; wrData = '0; outReady = 1'b0; clearOvf = 1'b0;
      #3;
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_valid", 32'(outValid), 32'd0);
      checkOutput("rst_ovf", 32'(overflow), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Single word
      applyStimulus(1'b1, 32'h0000_00A5, 1'b0, 1'b0);
      checkOutput("single_valid", 32'(outValid), 32'd1);
      checkOutput("single_data", outData, 32'hA5);
      checkOutput("single_count", 32'(count), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("single_empty", 32'(empty), 32'd1);
`ifdef OUTPORT_SINK_SEG7_EN
      checkOutput("seg_disp1", 32'(display1), 32'h92);
      checkOutput("seg_disp2", 32'(display2), 32'h88);
`endif

      // Fill and drop
      applyStimulus(1'b1, 32'h11, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h22, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h33, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h44, 1'b0, 1'b0);
      checkOutput("fill_full", 32'(full), 32'd1);
      checkOutput("fill_ovf_pre", 32'(overflow), 32'd0);
      applyStimulus(1'b1, 32'h55, 1'b0, 1'b0);
      checkOutput("drop_count", 32'(count), 32'd4);
      checkOutput("drop_full", 32'(full), 32'd1);
      checkOutput("drop_ovf", 32'(overflow), 32'd1);
      checkOutput("drop_head", outData, 32'h11);

      // Full pass-through: 11 leaves, 66 takes its slot
      applyStimulus(1'b1, 32'h66, 1'b1, 1'b0);
      checkOutput("pass_count", 32'(count), 32'd4);
      checkOutput("pass_ovf", 32'(overflow), 32'd1);
      checkOutput("pass_head", outData, 32'h22);

      // Clear racing a drop keeps the flag; clear alone removes it
      applyStimulus(1'b1, 32'h99, 1'b0, 1'b1);
      checkOutput("race_ovf", 32'(overflow), 32'd1);
      checkOutput("race_count", 32'(count), 32'd4);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("clear_ovf", 32'(overflow), 32'd0);

      begin
         logic [31:0] drainOrder [4];
         drainOrder = '{32'h22, 32'h33, 32'h44, 32'h66};
         for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain_%0d", i), outData, drainOrder[i]);
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
         end
      end
      checkOutput("drain_empty", 32'(empty), 32'd1);
`ifdef OUTPORT_SINK_SEG7_EN
      checkOutput("seg_last1", 32'(display1), 32'h82);
      checkOutput("seg_last2", 32'(display2), 32'h82);
`endif

      // Wrap-around: pointers cross the end of storage several times
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
         checkOutput($sformatf("wrap_data_%0d", i), outData, 32'(i));
         checkOutput($sformatf("wrap_full_%0d", i), 32'(full), 32'd0);
         applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      end
      checkOutput("wrap_empty", 32'(empty), 32'd1);
      checkOutput("wrap_ovf", 32'(overflow), 32'd0);

      // Simultaneous push and pop below full keeps the count
      applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hA2, 1'b1, 1'b0);
      checkOutput("pp_count", 32'(count), 32'd1);
      checkOutput("pp_head", outData, 32'hA2);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

      // Mid-stream reset
      applyStimulus(1'b1, 32'h1, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h2, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h3, 1'b0, 1'b0);
      checkOutput("mid_count_pre", 32'(count), 32'd3);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("mid_valid", 32'(outValid), 32'd0);
      checkOutput("mid_count", 32'(count), 32'd0);
      wrEn = 1'b1; wrData = 32'hEE; outReady = 1'b1; clearOvf = 1'b1;
      @(posedge clock); #1;
      checkOutput("mid_ignore", 32'(count), 32'd0);
`ifdef OUTPORT_SINK_SEG7_EN
      checkOutput("seg_rst1", 32'(display1), 32'hC0);
      checkOutput("seg_rst2", 32'(display2), 32'hC0);
`endif
      wrEn = 1'b0; outReady = 1'b0; clearOvf = 1'b0;
      #2;
      reset = 1'b0;
      @(posedge clock); #1;
      checkOutput("post_rst_empty", 32'(empty), 32'd1);
      applyStimulus(1'b1, 32'h77, 1'b0, 1'b0);
      checkOutput("post_rst_head", outData, 32'h77);
      checkOutput("post_rst_count", 32'(count), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("post_rst_drained", 32'(empty), 32'd1);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
